add_seq: RTL and testbench
==========================

Name: add_seq

Overview:
- Parametrised, multi-cycle successor to the combinational 4-bit adder.
- Adds or subtracts two WIDTH-bit operands CHUNK bits per clock, rippling the carry through an internal register.
- Valid/ready handshakes on both input and output, so it can sit between pipeline stages and be driven by a task-based bench.
- Reports the result, the carry-out and signed overflow.

Parameters:
- WIDTH, 16, operand/result width in bits; must be an integer multiple of CHUNK.
- CHUNK, 4, bits processed per cycle; 1 <= CHUNK <= WIDTH.
- NCHUNK, WIDTH/CHUNK, derived (localparam), number of RUN cycles per operation.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset.
- in_valid  input  1  operands and sub are valid.
- in_ready  output  1  block can accept an operation.
- in1  input  WIDTH  operand A (unsigned, or two's complement for overflow).
- in2  input  WIDTH  operand B.
- sub  input  1  0 = in1+in2; 1 = in1-in2.
- out_valid  output  1  out/carry/overflow are valid.
- out_ready  input  1  consumer takes the result.
- out  output  WIDTH  result.
- carry  output  1  carry-out of the MSB; for sub, 1 = no borrow.
- overflow  output  1  signed two's-complement overflow.

Interface note: one clock; reset is synchronous and active-low. Clock port is clk, reset port is rst_n.

Behaviour:
- FSM states: IDLE, RUN, DONE.
- Reset (rst_n=0 at a clk edge), from any state including mid-RUN:
  - state=IDLE, in_ready=1, out_valid=0, out=0, carry=0, overflow=0.
  - chunk index and internal carry cleared.
  - The in-flight operation is discarded; no out_valid pulse follows reset.
- IDLE:
  - in_ready=1.
  - On the edge where in_valid&in_ready: latch in1, in2^{WIDTH{sub}}, and sub.
  - Carry register := sub; index := 0; go to RUN.
  - Inputs are ignored outside the accepting edge.
- RUN:
  - in_ready=0.
  - Each edge computes chunk[idx] = A_chunk + B_chunk + c.
  - The chunk result is written into result bits [idx*CHUNK +: CHUNK]; c := chunk carry-out; idx++.
  - After the edge processing idx=NCHUNK-1, go to DONE.
  - carry := final c.
  - overflow := (A[MSB]==B'[MSB]) && (result[MSB]!=A[MSB]), using the inverted B for sub.
- DONE:
  - out_valid=1; out/carry/overflow held stable.
  - On an edge with out_ready=1: out_valid:=0, go to IDLE.
  - out/carry/overflow keep their last values until the next DONE.
- Latency: out_valid rises exactly NCHUNK edges after the accepting edge.
  - Earliest next accept is one edge after the out_ready handshake.
  - Throughput is one operation per NCHUNK+2 cycles.
- in_ready is asserted only in IDLE, so accept and result handshakes never coincide.
- Out-of-state handshake signals:
  - out_ready in IDLE/RUN is ignored.
  - in_valid held high during RUN/DONE does not queue a second operation.
- Width rules:
  - No operand extension.
  - Result wraps modulo 2^WIDTH; carry/overflow are the only wider information.
- CHUNK=WIDTH degenerates to a single RUN cycle (latency 1) and must work.
- Illegal parameters (WIDTH % CHUNK != 0) stop elaboration via a generate-time error.

Optional Feature:
- Macro: ADD_SEQ_SAT_EN.
- When defined, out saturates as unsigned on the DONE transition:
  - add with carry=1 -> all ones;
  - sub with carry=0 (borrow) -> all zeros.
  - carry and overflow still report raw (unsaturated) values.
- When undefined, out is the wrapped modulo-2^WIDTH result.
- Without the macro no saturation logic is generated.

Test Plan:
- Basic add, WIDTH=16, CHUNK=4:
  - in1=0x00FF, in2=0x0001, sub=0 -> out=0x0100, carry=0, overflow=0.
  - out_valid 4 edges after accept.
- Full-width carry ripple:
  - in1=0xFFFF, in2=0x0001 -> out=0x0000 (0xFFFF with ADD_SEQ_SAT_EN), carry=1, overflow=0.
- Subtract with borrow:
  - in1=0x0005, in2=0x0007, sub=1 -> out=0xFFFE (0x0000 with ADD_SEQ_SAT_EN), carry=0, overflow=0.
  - in1=0x0007, in2=0x0005, sub=1 -> out=0x0002, carry=1.
- Signed overflow:
  - in1=0x7FFF, in2=0x0001 -> out=0x8000, overflow=1.
  - in1=0x8000, in2=0x0001, sub=1 -> out=0x7FFF, overflow=1.
- Backpressure and reset:
  - Hold out_ready=0 for 10 cycles in DONE -> out_valid and out stable, in_ready=0.
  - Separately, drop rst_n for one edge during RUN (idx=2) -> IDLE next edge, out_valid never asserted, next operation correct.
- Exhaustive sweep:
  - WIDTH=4, CHUNK=1 and CHUNK=4, all 256 (in1,in2) pairs for sub=0 and sub=1.
  - Compare against a behavioural model; any mismatch fails.

Source files
------------

// File: rtl/add_seq_if.sv
// rtl/add_seq_if.sv - operand/result handshake bundle for add_seq
interface add_seq_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             carry;
  logic             overflow;

  modport master (
    output in_valid, in1, in2, sub, out_ready,
    input  in_ready, out_valid, out, carry, overflow
  );

  modport slave (
    input  in_valid, in1, in2, sub, out_ready,
    output in_ready, out_valid, out, carry, overflow
  );
endinterface

// File: rtl/add_seq.sv
// rtl/add_seq.sv - multi-cycle chunked adder/subtractor with valid/ready handshakes
// Optional unsigned output saturation is enabled by defining ADD_SEQ_SAT_EN.
module add_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  add_seq_if.slave bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  generate
    if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
      $error("add_seq: WIDTH must be a positive integer multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_out;
  logic             r_c;
  logic             r_carry;
  logic             r_ovf;
  logic [IDXW-1:0]  r_idx;

  logic             w_accept;
  logic             w_last;
  int               w_shift;
  logic [CHUNK-1:0] w_a_chunk;
  logic [CHUNK-1:0] w_b_chunk;
  logic [CHUNK:0]   w_sum;
  logic [WIDTH-1:0] w_res_nxt;
  logic [WIDTH-1:0] w_out_fin;
  logic             w_ovf_fin;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    w_accept      = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus.in_ready = 1'b1;
        w_accept     = bus.in_valid;
        if (bus.in_valid) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // One chunk per cycle: slice the operands at the current index and merge the sum back in place.
  assign w_shift   = int'(r_idx) * CHUNK;
  assign w_a_chunk = CHUNK'(r_a >> w_shift);
  assign w_b_chunk = CHUNK'(r_b >> w_shift);
  assign w_sum     = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + (CHUNK+1)'(r_c);
  assign w_res_nxt = (r_res & ~(WIDTH'({CHUNK{1'b1}}) << w_shift))
                   | (WIDTH'(w_sum[CHUNK-1:0]) << w_shift);
  assign w_last    = (r_idx == IDXW'(NCHUNK - 1));
  assign w_ovf_fin = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_res_nxt[WIDTH-1] != r_a[WIDTH-1]);

`ifdef ADD_SEQ_SAT_EN
  logic r_sub;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sub <= 1'b0;
    end else if (w_accept) begin
      r_sub <= bus.sub;
    end
  end

  // Unsigned clamp: add overflow pins high, subtract borrow pins low.
  always_comb begin
    w_out_fin = w_res_nxt;
    if (!r_sub && w_sum[CHUNK]) begin
      w_out_fin = '1;
    end else if (r_sub && !w_sum[CHUNK]) begin
      w_out_fin = '0;
    end
  end
`else
  assign w_out_fin = w_res_nxt;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_out   <= '0;
      r_c     <= 1'b0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
      r_idx   <= '0;
    end else if (w_accept) begin
      r_a   <= bus.in1;
      r_b   <= bus.in2 ^ {WIDTH{bus.sub}};
      r_c   <= bus.sub;
      r_idx <= '0;
      r_res <= '0;
    end else if (r_state == S_RUN) begin
      r_res <= w_res_nxt;
      r_c   <= w_sum[CHUNK];
      r_idx <= r_idx + IDXW'(1);
      if (w_last) begin
        r_out   <= w_out_fin;
        r_carry <= w_sum[CHUNK];
        r_ovf   <= w_ovf_fin;
      end
    end
  end

  assign bus.out      = r_out;
  assign bus.carry    = r_carry;
  assign bus.overflow = r_ovf;
endmodule

// File: tb/tb_add_seq.sv
// tb/tb_add_seq.sv - self-checking bench for add_seq (16/4 vectors, 4-bit exhaustive sweeps)
module tb_add_seq;
`ifdef ADD_SEQ_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] o;
    logic        c;
    logic        v;
  } res16_t;

  typedef struct packed {
    logic [3:0] o;
    logic       c;
    logic       v;
  } res4_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        s;
    res16_t      r;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  res16_t q16[$];
  res4_t  q4a[$];
  res4_t  q4b[$];

  always #5 clk = ~clk;

  add_seq_if #(.WIDTH(16)) b16 ();
  add_seq_if #(.WIDTH(4))  f4a ();
  add_seq_if #(.WIDTH(4))  f4b ();

  add_seq #(.WIDTH(16), .CHUNK(4)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(b16));
  add_seq #(.WIDTH(4),  .CHUNK(1)) u_dut4a (.clk(clk), .rst_n(rst_n), .bus(f4a));
  add_seq #(.WIDTH(4),  .CHUNK(4)) u_dut4b (.clk(clk), .rst_n(rst_n), .bus(f4b));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic res16_t model16(input logic [15:0] a, input logic [15:0] b, input logic s);
    logic [15:0] bb;
    logic [16:0] full;
    res16_t      r;
    bb   = s ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + 17'(s);
    r.o  = full[15:0];
    r.c  = full[16];
    r.v  = (a[15] == bb[15]) && (full[15] != a[15]);
    if (SAT && !s && r.c) r.o = 16'hFFFF;
    if (SAT && s && !r.c) r.o = 16'h0000;
    return r;
  endfunction

  function automatic res4_t model4(input logic [3:0] a, input logic [3:0] b, input logic s);
    logic [3:0] bb;
    logic [4:0] full;
    res4_t      r;
    bb   = s ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + 5'(s);
    r.o  = full[3:0];
    r.c  = full[4];
    r.v  = (a[3] == bb[3]) && (full[3] != a[3]);
    if (SAT && !s && r.c) r.o = 4'hF;
    if (SAT && s && !r.c) r.o = 4'h0;
    return r;
  endfunction

  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic s,
                      input res16_t e, input bit early_rdy);
    int     lat;
    res16_t g;
    q16.push_back(e);
    b16.in1       = a;
    b16.in2       = b;
    b16.sub       = s;
    b16.in_valid  = 1'b1;
    b16.out_ready = early_rdy;
    @(posedge clk); #1;
    b16.in_valid = 1'b0;
    lat = 0;
    while (!b16.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    g = q16.pop_front();
    if (!b16.out_valid) begin
      check("op16_timeout", 32'(b16.out_valid), 32'd1);
      b16.out_ready = 1'b0;
    end else begin
      check("op16_result", 32'({b16.out, b16.carry, b16.overflow}), 32'(g));
      check("op16_latency", 32'(lat), 32'd4);
      b16.out_ready = 1'b1;
      @(posedge clk); #1;
      b16.out_ready = 1'b0;
      check("op16_release", 32'({b16.out_valid, b16.in_ready}), 32'b01);
    end
  endtask

  // Both 4-bit DUTs take the same operation; each is drained as soon as it reports.
  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic s);
    int    cyc;
    bit    got_a;
    bit    got_b;
    res4_t e;
    e = model4(a, b, s);
    q4a.push_back(e);
    q4b.push_back(e);
    f4a.in1 = a; f4a.in2 = b; f4a.sub = s; f4a.in_valid = 1'b1;
    f4b.in1 = a; f4b.in2 = b; f4b.sub = s; f4b.in_valid = 1'b1;
    @(posedge clk); #1;
    f4a.in_valid = 1'b0;
    f4b.in_valid = 1'b0;
    got_a = 1'b0;
    got_b = 1'b0;
    cyc   = 0;
    while (!(got_a && got_b) && cyc < 20) begin
      if (!got_a && f4a.out_valid) begin
        got_a = 1'b1;
        e = q4a.pop_front();
        check("sweep_chunk1", 32'({f4a.out, f4a.carry, f4a.overflow, 8'(cyc)}), 32'({e, 8'd4}));
        f4a.out_ready = 1'b1;
      end
      if (!got_b && f4b.out_valid) begin
        got_b = 1'b1;
        e = q4b.pop_front();
        check("sweep_chunk4", 32'({f4b.out, f4b.carry, f4b.overflow, 8'(cyc)}), 32'({e, 8'd1}));
        f4b.out_ready = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
      f4a.out_ready = 1'b0;
      f4b.out_ready = 1'b0;
    end
    if (!(got_a && got_b)) begin
      check("sweep_timeout", 32'({got_a, got_b}), 32'b11);
    end
  endtask

  initial begin
    vec_t    vecs[9];
    res16_t  e;
    int      lat;
    bit      seen;
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rs;

    vecs[0] = '{16'h00FF, 16'h0001, 1'b0, '{16'h0100, 1'b0, 1'b0}};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, '{SAT ? 16'hFFFF : 16'h0000, 1'b1, 1'b0}};
    vecs[2] = '{16'h0005, 16'h0007, 1'b1, '{SAT ? 16'h0000 : 16'hFFFE, 1'b0, 1'b0}};
    vecs[3] = '{16'h0007, 16'h0005, 1'b1, '{16'h0002, 1'b1, 1'b0}};
    vecs[4] = '{16'h7FFF, 16'h0001, 1'b0, '{16'h8000, 1'b0, 1'b1}};
    vecs[5] = '{16'h8000, 16'h0001, 1'b1, '{16'h7FFF, 1'b1, 1'b1}};
    vecs[6] = '{16'h1234, 16'h4321, 1'b0, '{16'h5555, 1'b0, 1'b0}};
    vecs[7] = '{16'h8000, 16'h8000, 1'b0, '{SAT ? 16'hFFFF : 16'h0000, 1'b1, 1'b1}};
    vecs[8] = '{16'h0000, 16'h0000, 1'b1, '{16'h0000, 1'b1, 1'b0}};

    b16.in_valid = 1'b0; b16.in1 = '0; b16.in2 = '0; b16.sub = 1'b0; b16.out_ready = 1'b0;
    f4a.in_valid = 1'b0; f4a.in1 = '0; f4a.in2 = '0; f4a.sub = 1'b0; f4a.out_ready = 1'b0;
    f4b.in_valid = 1'b0; f4b.in1 = '0; f4b.in2 = '0; f4b.sub = 1'b0; f4b.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("reset16", 32'({b16.in_ready, b16.out_valid, b16.out, b16.carry, b16.overflow}), 32'h1_0000 << 3);
    check("reset4a", 32'({f4a.in_ready, f4a.out_valid, f4a.out, f4a.carry, f4a.overflow}), 32'h80);
    check("reset4b", 32'({f4b.in_ready, f4b.out_valid, f4b.out, f4b.carry, f4b.overflow}), 32'h80);

    for (int i = 0; i < 9; i++) begin
      op16(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].r, 1'b0);
    end

    for (int i = 0; i < 6; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 1'($urandom);
      op16(ra, rb, rs, model16(ra, rb, rs), 1'b1);
    end

    // Backpressure in DONE, with in_valid held and operands scrambled after the accept.
    b16.in1 = 16'h1234; b16.in2 = 16'h4321; b16.sub = 1'b0; b16.in_valid = 1'b1;
    @(posedge clk); #1;
    b16.in1 = 16'hFFFF; b16.in2 = 16'hFFFF; b16.sub = 1'b1;
    lat = 0;
    while (!b16.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp_latency", 32'(lat), 32'd4);
    for (int i = 0; i < 10; i++) begin
      check("bp_hold", 32'({b16.out_valid, b16.in_ready, b16.out, b16.carry, b16.overflow}),
            32'({1'b1, 1'b0, 16'h5555, 1'b0, 1'b0}));
      @(posedge clk); #1;
    end
    b16.in_valid  = 1'b0;
    b16.out_ready = 1'b1;
    @(posedge clk); #1;
    b16.out_ready = 1'b0;
    check("bp_release", 32'({b16.out_valid, b16.in_ready, b16.out}), 32'({1'b0, 1'b1, 16'h5555}));
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (b16.out_valid || !b16.in_ready) seen = 1'b1;
    end
    check("no_queued_op", 32'(seen), 32'd0);

    // Reset in the middle of RUN (after two chunks) must abort silently.
    b16.in1 = 16'hFFFF; b16.in2 = 16'h0001; b16.sub = 1'b0; b16.in_valid = 1'b1;
    @(posedge clk); #1;
    b16.in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    check("pre_reset_busy", 32'({b16.in_ready, b16.out_valid}), 32'b00);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrun_reset", 32'({b16.in_ready, b16.out_valid, b16.out, b16.carry, b16.overflow}),
          32'({1'b1, 1'b0, 16'h0000, 1'b0, 1'b0}));
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (b16.out_valid) seen = 1'b1;
    end
    check("reset_no_valid", 32'(seen), 32'd0);
    op16(vecs[5].a, vecs[5].b, vecs[5].s, vecs[5].r, 1'b0);
    e = model16(16'hABCD, 16'h1234, 1'b1);
    op16(16'hABCD, 16'h1234, 1'b1, e, 1'b0);

    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          op4(4'(a), 4'(b), 1'(s));
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
